// File: rtl/autoconfig_host_if.sv
// AUTOCONFIG bus between the host sequencer (master) and the board chain (slave).
interface autoconfig_host_if;
   logic [23:1] ADDR;
   logic [3:0]  DOUT;
   logic        RW;
   logic        AS_n;
   logic        DTACK;
   logic [3:0]  DIN;

   modport master (output ADDR, DOUT, RW, AS_n, input DTACK, DIN);
   modport slave  (input ADDR, DOUT, RW, AS_n, output DTACK, DIN);
endinterface

// File: rtl/autoconfig_host.sv
// AUTOCONFIG host: walks the board chain at $E80000, places memory boards from $200000 and shuts up the rest.
// Define AUTOCONFIG_HOST_IO_ALLOC_EN to also place 64K I/O boards from $E90000 upward.
module autoconfig_host (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   autoconfig_host_if.master bus,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERROR,
   output logic [2:0]        BOARD_COUNT
);
   typedef enum logic [3:0] {
      IDLE, RD_HI, RD_LO, ALLOC, WR_LO, WR_HI, SHUTUP, GAP, FINISH
   } state_t;

   localparam logic [23:1] A_TYPE_HI  = 23'h740000;
   localparam logic [23:1] A_TYPE_LO  = 23'h740001;
   localparam logic [23:1] A_BASE_HI  = 23'h740024;
   localparam logic [23:1] A_BASE_LO  = 23'h740025;
   localparam logic [23:1] A_SHUTUP   = 23'h740026;
   localparam logic [7:0]  MEM_START  = 8'h20;
   localparam logic [8:0]  MEM_LIMIT  = 9'h0A0;
   localparam logic [7:0]  TMO_LAST   = 8'd254;
   localparam logic [2:0]  MAX_BOARDS = 3'd7;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
   localparam logic [7:0]  IO_START   = 8'hE9;
   localparam logic [7:0]  IO_LAST    = 8'hEF;
`endif

   // Board size in 64K units (A23:16 granules).
   function automatic logic [7:0] size_units(input logic [2:0] code);
      return (code == 3'b000) ? 8'h80 : (8'h01 << (code - 3'd1));
   endfunction

   // The 8MB window itself starts at $200000, so an 8MB board only needs 2MB alignment.
   function automatic logic [7:0] align_units(input logic [2:0] code);
      return (code == 3'b000) ? 8'h20 : size_units(code);
   endfunction

   function automatic logic [8:0] align_up(input logic [7:0] ptr, input logic [7:0] align);
      logic [8:0] mask;
      mask = {1'b0, align} - 9'd1;
      return ({1'b0, ptr} + mask) & ~mask;
   endfunction

   state_t      state_q, state_d, gap_next_q, gap_next_d, setup_state;
   logic        setup, ack;
   logic        as_n_q, as_n_d, rw_q, rw_d;
   logic [23:1] addr_q, addr_d;
   logic [3:0]  dout_q, dout_d;
   logic        done_q, done_d, error_q, error_d;
   logic [2:0]  count_q, count_d;
   logic [7:0]  memptr_q, memptr_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        is_mem_q, is_mem_d;
   logic [2:0]  size_q, size_d;
   logic [7:0]  base_q, base_d;
   logic [8:0]  mem_base, mem_end;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
   logic [7:0]  ioptr_q, ioptr_d;
`endif

   assign mem_base = align_up(memptr_q, align_units(size_q));
   assign mem_end  = mem_base + {1'b0, size_units(size_q)};

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         gap_next_q <= IDLE;
         as_n_q     <= 1'b1;
         rw_q       <= 1'b1;
         addr_q     <= '0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         count_q    <= '0;
         memptr_q   <= MEM_START;
         tmo_q      <= '0;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
         ioptr_q    <= IO_START;
`endif
      end else begin
         state_q    <= state_d;
         gap_next_q <= gap_next_d;
         as_n_q     <= as_n_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         error_q    <= error_d;
         count_q    <= count_d;
         memptr_q   <= memptr_d;
         tmo_q      <= tmo_d;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
         ioptr_q    <= ioptr_d;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      is_mem_q <= is_mem_d;
      size_q   <= size_d;
      base_q   <= base_d;
   end

   always_comb begin
      state_d     = state_q;
      gap_next_d  = gap_next_q;
      as_n_d      = as_n_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      done_d      = done_q;
      error_d     = error_q;
      count_d     = count_q;
      memptr_d    = memptr_q;
      tmo_d       = tmo_q;
      is_mem_d    = is_mem_q;
      size_d      = size_q;
      base_d      = base_q;
      setup       = 1'b0;
      setup_state = IDLE;
      ack         = 1'b0;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
      ioptr_d     = ioptr_q;
`endif

      // A strobed cycle ends on DTACK, or after 255 silent clocks meaning no board is there.
      if (!as_n_q) begin
         if (bus.DTACK) begin
            as_n_d = 1'b1;
            tmo_d  = '0;
            ack    = 1'b1;
         end else if (tmo_q == TMO_LAST) begin
            as_n_d  = 1'b1;
            tmo_d   = '0;
            state_d = FINISH;
         end else begin
            tmo_d = tmo_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: if (START) begin
            done_d      = 1'b0;
            error_d     = 1'b0;
            count_d     = '0;
            memptr_d    = MEM_START;
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
            ioptr_d     = IO_START;
`endif
            setup       = 1'b1;
            setup_state = RD_HI;
         end
         RD_HI: if (ack) begin
            is_mem_d = bus.DIN[1];
            if (bus.DIN[3:2] != 2'b11) begin
               state_d = FINISH;
            end else begin
               setup       = 1'b1;
               setup_state = RD_LO;
            end
         end
         RD_LO: if (ack) begin
            size_d  = bus.DIN[2:0];
            state_d = ALLOC;
         end
         ALLOC: begin
            setup       = 1'b1;
            setup_state = SHUTUP;
            if (is_mem_q) begin
               if (mem_end <= MEM_LIMIT) begin
                  base_d      = mem_base[7:0];
                  memptr_d    = mem_end[7:0];
                  setup_state = WR_LO;
               end
            end
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
            else if (size_q == 3'b001 && ioptr_q <= IO_LAST) begin
               base_d      = ioptr_q;
               ioptr_d     = ioptr_q + 8'd1;
               setup_state = WR_LO;
            end
`endif
         end
         WR_LO: if (ack) begin
            setup       = 1'b1;
            setup_state = WR_HI;
         end
         WR_HI: if (ack) begin
            count_d = count_q + 3'd1;
            if (count_q == MAX_BOARDS - 3'd1) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else begin
               setup       = 1'b1;
               setup_state = RD_HI;
            end
         end
         SHUTUP: if (ack) begin
            setup       = 1'b1;
            setup_state = RD_HI;
         end
         GAP: begin
            state_d = gap_next_q;
            as_n_d  = 1'b0;
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Address, direction and data go out during GAP so they lead the strobe by a clock.
      if (setup) begin
         state_d    = GAP;
         gap_next_d = setup_state;
         rw_d       = 1'b0;
         dout_d     = 4'h0;
         case (setup_state)
            RD_HI: begin
               addr_d = A_TYPE_HI;
               rw_d   = 1'b1;
            end
            RD_LO: begin
               addr_d = A_TYPE_LO;
               rw_d   = 1'b1;
            end
            WR_LO: begin
               addr_d = A_BASE_LO;
               dout_d = base_d[3:0];
            end
            WR_HI: begin
               addr_d = A_BASE_HI;
               dout_d = base_d[7:4];
            end
            default: addr_d = A_SHUTUP;
         endcase
      end
   end

   assign bus.ADDR    = addr_q;
   assign bus.DOUT    = dout_q;
   assign bus.RW      = rw_q;
   assign bus.AS_n    = as_n_q;
   assign BUSY        = (state_q != IDLE);
   assign DONE        = done_q;
   assign ERROR       = error_q;
   assign BOARD_COUNT = count_q;
endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: board-chain model, expected-write scoreboard, table of enumeration scenarios.
module tb_autoconfig_host;
   localparam logic [22:0] A_TYPE_HI = 23'h740000;
   localparam logic [22:0] A_TYPE_LO = 23'h740001;
   localparam logic [22:0] A_BASE_HI = 23'h740024;
   localparam logic [22:0] A_BASE_LO = 23'h740025;
   localparam logic [22:0] A_SHUTUP  = 23'h740026;
   localparam int NVEC = 10;

   // typ/base: board i in bits [8*i +: 8]; base 8'h00 = expect shut-up, 8'hFF = expect no write
   typedef struct packed {
      logic [3:0]  nb;
      logic [63:0] typ;
      logic [63:0] base;
      logic [2:0]  count;
      logic        err;
   } vec_t;

   logic       CLK   = 1'b0;
   logic       RESET = 1'b1;
   logic       START = 1'b0;
   logic       BUSY, DONE, ERROR;
   logic [2:0] BOARD_COUNT;

   autoconfig_host_if bus ();

   autoconfig_host dut (
      .CLK(CLK), .RESET(RESET), .START(START), .bus(bus),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .BOARD_COUNT(BOARD_COUNT)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [26:0] exp_q [$];
   logic [7:0]  btype [8];
   int          nb = 0, cur = 0, lat = 0, wcnt = 0;
   bit          adv = 1'b0;
   logic [22:0] prev_addr = '0;
   logic [3:0]  prev_dout = '0;
   logic        prev_rw = 1'b1, prev_as = 1'b1;
   int          low_run = 0, last_low = 0;
   vec_t        vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Board chain: the current board answers after a short random delay and drops out after base/shut-up write.
   always @(negedge CLK) begin
      if (bus.AS_n !== 1'b0) begin
         bus.DTACK = 1'b0;
         wcnt = 0;
         if (adv) begin
            cur++;
            adv = 1'b0;
         end
      end else if (cur < nb) begin
         if (wcnt == 0) lat = $urandom_range(0, 2);
         if (wcnt >= lat && bus.DTACK !== 1'b1) begin
            bus.DTACK = 1'b1;
            case (bus.ADDR)
               A_TYPE_HI:           bus.DIN = btype[cur][7:4];
               A_TYPE_LO:           bus.DIN = btype[cur][3:0];
               A_BASE_HI, A_SHUTUP: adv = 1'b1;
               default: ;
            endcase
         end
         wcnt++;
      end
   end

   // Bus monitor: setup/hold stability, write scoreboard, strobe length.
   always @(negedge CLK) begin
      if (bus.AS_n === 1'b0) begin
         check("bus hold", {bus.RW, bus.DOUT, bus.ADDR}, {prev_rw, prev_dout, prev_addr});
         if (prev_as && bus.RW === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected write: addr %0h data %0h, none queued", bus.ADDR, bus.DOUT);
            end else begin
               check("write", {bus.ADDR, bus.DOUT}, exp_q.pop_front());
            end
         end
         low_run++;
      end else begin
         if (!prev_as) last_low = low_run;
         low_run = 0;
      end
      prev_as   = bus.AS_n;
      prev_rw   = bus.RW;
      prev_dout = bus.DOUT;
      prev_addr = bus.ADDR;
   end

   task automatic load(input vec_t v);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) btype[i] = v.typ[8*i +: 8];
      nb  = int'(v.nb);
      cur = 0;
      adv = 1'b0;
      for (int i = 0; i < int'(v.nb); i++) begin
         b = v.base[8*i +: 8];
         if (b == 8'h00) begin
            exp_q.push_back({A_SHUTUP, 4'h0});
         end else if (b != 8'hFF) begin
            exp_q.push_back({A_BASE_LO, b[3:0]});
            exp_q.push_back({A_BASE_HI, b[7:4]});
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 6000; c++) begin
         if (DONE === 1'b1) break;
         @(negedge CLK);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      load(v);
      pulse_start();
      check({tag, " busy after start"}, BUSY, 1'b1);
      check({tag, " done cleared"}, DONE, 1'b0);
      wait_done();
      check({tag, " done"}, DONE, 1'b1);
      check({tag, " busy at end"}, BUSY, 1'b0);
      check({tag, " count"}, BOARD_COUNT, v.count);
      check({tag, " error"}, ERROR, v.err);
      check({tag, " writes left"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit   found;
      vec_t v;

      vecs[0] = '{nb: 4'd1, typ: 64'hE0,               base: 64'h20,               count: 3'd1, err: 1'b0};
      vecs[1] = '{nb: 4'd3, typ: 64'hE4E6E4,           base: 64'h604020,           count: 3'd3, err: 1'b0};
      vecs[2] = '{nb: 4'd2, typ: 64'hE0E6,             base: 64'h0020,             count: 3'd1, err: 1'b0};
`ifdef AUTOCONFIG_HOST_IO_ALLOC_EN
      vecs[3] = '{nb: 4'd1, typ: 64'hC1,               base: 64'hE9,               count: 3'd1, err: 1'b0};
      vecs[8] = '{nb: 4'd2, typ: 64'hC1C2,             base: 64'hE900,             count: 3'd1, err: 1'b0};
`else
      vecs[3] = '{nb: 4'd1, typ: 64'hC1,               base: 64'h00,               count: 3'd0, err: 1'b0};
      vecs[8] = '{nb: 4'd2, typ: 64'hC1C2,             base: 64'h0000,             count: 3'd0, err: 1'b0};
`endif
      vecs[4] = '{nb: 4'd1, typ: 64'h80,               base: 64'hFF,               count: 3'd0, err: 1'b0};
      vecs[5] = '{nb: 4'd8, typ: 64'hE4E4E4E4E4E4E4E4, base: 64'hFF50484038302820, count: 3'd7, err: 1'b1};
      vecs[6] = '{nb: 4'd3, typ: 64'hE7E4E5,           base: 64'h403020,           count: 3'd3, err: 1'b0};
      vecs[7] = '{nb: 4'd3, typ: 64'hE6E7E7,           base: 64'h800040,           count: 3'd2, err: 1'b0};
      vecs[9] = '{nb: 4'd2, typ: 64'hE5E1,             base: 64'h3020,             count: 3'd2, err: 1'b0};

      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset AS_n", bus.AS_n, 1'b1);
      check("reset RW", bus.RW, 1'b1);
      check("reset ADDR", bus.ADDR, 23'h0);
      check("reset DOUT", bus.DOUT, 4'h0);
      check("reset BUSY", BUSY, 1'b0);
      check("reset DONE", DONE, 1'b0);
      check("reset ERROR", ERROR, 1'b0);
      check("reset BOARD_COUNT", BOARD_COUNT, 3'd0);
      RESET = 1'b0;

      for (int i = 0; i < NVEC; i++) run_vec($sformatf("v%0d", i), vecs[i]);

      // START during enumeration must not restart allocation.
      load(vecs[1]);
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge CLK);
         if (BOARD_COUNT == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      check("busy start first board", found, 1'b1);
      pulse_start();
      check("busy start still busy", BUSY, 1'b1);
      wait_done();
      check("busy start done", DONE, 1'b1);
      check("busy start count", BOARD_COUNT, 3'd3);
      check("busy start writes left", exp_q.size(), 0);
      exp_q.delete();

      // Empty slot: first read times out after exactly 255 strobed clocks.
      v = '{nb: 4'd0, typ: 64'h0, base: 64'h0, count: 3'd0, err: 1'b0};
      run_vec("timeout", v);
      check("timeout strobe length", last_low, 255);

      // Reset during the second board's WR_LO strobe, then re-enumerate from $200000.
      load(vecs[1]);
      pulse_start();
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge CLK);
         if (bus.AS_n === 1'b0 && bus.ADDR == A_BASE_LO && BOARD_COUNT == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      check("mid reset reached WR_LO", found, 1'b1);
      #2 RESET = 1'b1;
      #1;
      check("mid reset AS_n", bus.AS_n, 1'b1);
      check("mid reset RW", bus.RW, 1'b1);
      check("mid reset ADDR", bus.ADDR, 23'h0);
      check("mid reset DOUT", bus.DOUT, 4'h0);
      check("mid reset BUSY", BUSY, 1'b0);
      check("mid reset BOARD_COUNT", BOARD_COUNT, 3'd0);
      check("mid reset DONE", DONE, 1'b0);
      check("mid reset ERROR", ERROR, 1'b0);
      @(negedge CLK);
      RESET = 1'b0;
      exp_q.delete();
      run_vec("after reset", vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
